// File: rtl/spi_resp_pkg.sv
// Shared types and defaults for the SPI sample responder.
package spi_resp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int FRAME_BITS_DEF = 16;

    typedef logic [15:0] sample_t;

    localparam sample_t UNDERRUN_WORD_DEF = 16'h0000;

endpackage

// File: rtl/spi_resp_fifo.sv
// Synchronous sample FIFO: wrap-around pointers plus a separate occupancy count.
module spi_resp_fifo
    import spi_resp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == LW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign level_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A full FIFO refuses the push even when a pop happens in the same cycle.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + LW'(1);
                2'b01:   count_q <= count_q - LW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/spi_sample_responder.sv
// SPI responder that shifts one buffered 16-bit sample per CS_b frame, oversampling sclk/CS_b on PCLK.
// Optional counting test pattern source: define SPI_RESP_PATTERN_EN.
module spi_sample_responder
    import spi_resp_pkg::*;
#(
    parameter int                  FRAME_BITS    = FRAME_BITS_DEF,
    parameter int                  FIFO_DEPTH    = 4,
    parameter logic [FRAME_BITS-1:0] UNDERRUN_WORD = FRAME_BITS'(UNDERRUN_WORD_DEF)
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    input  logic                          CS_b,
    input  logic                          sclk,
    output logic                          MISO,
    output logic                          MISO_oe,
    input  logic [FRAME_BITS-1:0]         s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    input  logic                          clr_status,
`ifdef SPI_RESP_PATTERN_EN
    input  logic                          pattern_mode,
`endif
    output logic                          underrun,
    output logic                          frame_abort
);

    localparam int CW = $clog2(FRAME_BITS);

    logic cs_meta_q, cs_sync_q, cs_hist_q;
    logic sclk_meta_q, sclk_sync_q, sclk_hist_q;
    logic cs_fall, cs_rise, sclk_fall;

    state_t                state_q, state_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  underrun_q, underrun_d;
    logic                  abort_q, abort_d;
    logic                  set_underrun, set_abort;

    logic                  fifo_pop, fifo_full, fifo_empty;
    logic [FRAME_BITS-1:0] fifo_rdata;

    logic                  use_pattern, pattern_start;
    logic [FRAME_BITS-1:0] pattern_word;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            cs_hist_q   <= 1'b1;
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_hist_q <= 1'b0;
        end else begin
            cs_meta_q   <= CS_b;
            cs_sync_q   <= cs_meta_q;
            cs_hist_q   <= cs_sync_q;
            sclk_meta_q <= sclk;
            sclk_sync_q <= sclk_meta_q;
            sclk_hist_q <= sclk_sync_q;
        end
    end

    assign cs_fall   =  cs_hist_q & ~cs_sync_q;
    assign cs_rise   = ~cs_hist_q &  cs_sync_q;
    assign sclk_fall =  sclk_hist_q & ~sclk_sync_q;

    spi_resp_fifo #(
        .WIDTH (FRAME_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (PCLK),
        .rst_n_i (PRESETn),
        .push_i  (s_valid),
        .wdata_i (s_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign s_ready = ~fifo_full;

`ifdef SPI_RESP_PATTERN_EN
    sample_t pat_cnt_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            pat_cnt_q <= '0;
        end else if (pattern_start) begin
            pat_cnt_q <= pat_cnt_q + 16'd1;
        end
    end

    assign use_pattern  = pattern_mode;
    assign pattern_word = FRAME_BITS'(pat_cnt_q);
`else
    assign use_pattern  = 1'b0;
    assign pattern_word = '0;
`endif

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        bit_cnt_d     = bit_cnt_q;
        fifo_pop      = 1'b0;
        set_underrun  = 1'b0;
        set_abort     = 1'b0;
        pattern_start = 1'b0;

        // CS_b release ends the frame from any state and outranks a coincident sclk edge.
        if (cs_rise) begin
            state_d = IDLE;
            if (state_q == SHIFT) set_abort = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_d   = SHIFT;
                        bit_cnt_d = '0;
                        if (use_pattern) begin
                            shreg_d       = pattern_word;
                            pattern_start = 1'b1;
                        end else if (fifo_empty) begin
                            shreg_d      = UNDERRUN_WORD;
                            set_underrun = 1'b1;
                        end else begin
                            shreg_d  = fifo_rdata;
                            fifo_pop = 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (sclk_fall) begin
                        shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
                        if (bit_cnt_q == CW'(FRAME_BITS - 1)) begin
                            state_d = DONE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CW'(1);
                        end
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end

        // Set outranks a coincident clear so no event is lost.
        underrun_d = clr_status ? 1'b0 : underrun_q;
        abort_d    = clr_status ? 1'b0 : abort_q;
        if (set_underrun) underrun_d = 1'b1;
        if (set_abort)    abort_d    = 1'b1;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            underrun_q <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            underrun_q <= underrun_d;
            abort_q    <= abort_d;
        end
    end

    assign MISO        = (state_q == SHIFT) ? shreg_q[FRAME_BITS-1] : 1'b0;
    assign MISO_oe     = (state_q != IDLE);
    assign underrun    = underrun_q;
    assign frame_abort = abort_q;

endmodule
